// File: rtl/burt_v_window_gen.sv
// rtl/burt_v_window_gen.sv - 5x1 vertical window generator for the Burt pyramid filter
// Row-rotating line buffers with edge replication and an end-of-frame flush phase.
module burt_v_window_gen #(
  parameter int FP_WIDTH      = 16,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int WINDOW_HEIGHT = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FP_WIDTH-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [FP_WIDTH-1:0] window_o [WINDOW_HEIGHT][1],
  output logic [15:0]         col_o,
  output logic [15:0]         row_o,
  output logic                valid_o
);

  localparam int HALF = (WINDOW_HEIGHT - 1) / 2;
  localparam int NBUF = WINDOW_HEIGHT - 1;
  localparam int BW   = $clog2(NBUF);
  localparam int AW   = $clog2(IMAGE_WIDTH);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [15:0]           in_col_q, in_col_d;
  logic [15:0]           in_row_q, in_row_d;
  logic [BW-1:0]         wp_q, wp_d;
  logic                  valid_q, valid_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [FP_WIDTH-1:0]   din_q, din_d;
  logic [BW-1:0]         sel_q [WINDOW_HEIGHT];
  logic [BW-1:0]         sel_d [WINDOW_HEIGHT];
  logic [WINDOW_HEIGHT-1:0] use_in_q, use_in_d;
  logic                  xfer, step;
  logic [AW-1:0]         col_addr;

  logic [FP_WIDTH-1:0]   line_mem [NBUF][IMAGE_WIDTH];
  logic [FP_WIDTH-1:0]   rd_data [NBUF];

  assign col_addr = in_col_q[AW-1:0];
  assign ready_o  = (state_q != FLUSH);
  assign valid_o  = valid_q;
  assign col_o    = col_q;
  assign row_o    = row_q;

  // Each row lands in buffer wp; row (current - m) lives in buffer wp - m.
  // In FLUSH the "current" row is the virtual row IMAGE_HEIGHT, never written.
  always_comb begin
    int c_row, b_row, a, m, idx;
    a        = 0;
    m        = 0;
    idx      = 0;
    xfer     = valid_i && (state_q != FLUSH);
    step     = xfer || (state_q == FLUSH);
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    wp_d     = wp_q;
    col_d    = col_q;
    row_d    = row_q;
    din_d    = din_q;
    use_in_d = use_in_q;
    sel_d    = sel_q;
    valid_d  = ((state_q == STREAM) && xfer) || (state_q == FLUSH);

    if (state_q == FLUSH) begin
      c_row = int'(in_row_q);
      b_row = IMAGE_HEIGHT;
    end else begin
      c_row = int'(in_row_q) - HALF;
      b_row = int'(in_row_q);
    end

    if (step) begin
      din_d = data_i;
      col_d = in_col_q;
      row_d = 16'(c_row);
      for (int k = 0; k < WINDOW_HEIGHT; k++) begin
        a = c_row - HALF + k;
        if (a < 0) a = 0;
        if (a > IMAGE_HEIGHT - 1) a = IMAGE_HEIGHT - 1;
        m   = b_row - a;
        idx = int'(wp_q) + NBUF - m;
        if (idx >= NBUF) idx = idx - NBUF;
        use_in_d[k] = (m == 0);
        sel_d[k]    = BW'(idx);
      end
    end

    if (xfer) begin
      if (in_col_q == 16'(IMAGE_WIDTH - 1)) begin
        in_col_d = '0;
        wp_d     = (wp_q == BW'(NBUF - 1)) ? '0 : wp_q + 1'b1;
        if (in_row_q == 16'(IMAGE_HEIGHT - 1)) begin
          in_row_d = 16'(IMAGE_HEIGHT - HALF);
          state_d  = FLUSH;
        end else begin
          in_row_d = in_row_q + 16'd1;
          if ((state_q == FILL) && (in_row_q == 16'(HALF - 1))) state_d = STREAM;
        end
      end else begin
        in_col_d = in_col_q + 16'd1;
      end
    end else if (state_q == FLUSH) begin
      if (in_col_q == 16'(IMAGE_WIDTH - 1)) begin
        in_col_d = '0;
        if (in_row_q == 16'(IMAGE_HEIGHT - 1)) begin
          in_row_d = '0;
          state_d  = FILL;
        end else begin
          in_row_d = in_row_q + 16'd1;
        end
      end else begin
        in_col_d = in_col_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= FILL;
      in_col_q <= '0;
      in_row_q <= '0;
      wp_q     <= '0;
      valid_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      din_q    <= '0;
      use_in_q <= '0;
      for (int k = 0; k < WINDOW_HEIGHT; k++) sel_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      wp_q     <= wp_d;
      valid_q  <= valid_d;
      col_q    <= col_d;
      row_q    <= row_d;
      din_q    <= din_d;
      use_in_q <= use_in_d;
      sel_q    <= sel_d;
    end
  end

  // Registered read before write at the same column keeps this a plain 1-cycle block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBUF; b++) begin
      if (step) rd_data[b] <= line_mem[b][col_addr];
      if (xfer && (wp_q == BW'(b))) line_mem[b][col_addr] <= data_i;
    end
  end

  always_comb begin
    for (int k = 0; k < WINDOW_HEIGHT; k++) begin
      window_o[k][0] = '0;
      if (valid_q) window_o[k][0] = use_in_q[k] ? din_q : rd_data[sel_q[k]];
    end
  end

endmodule
